branch_redirect_ctrl: RTL and testbench

Decode-stage branch sequencer for the 5-stage MIPS pipeline. It sits behind the combinational branch judge and turns its per-cycle verdict into the ordered pipeline actions:
- stall ID/IF while branch operands are unresolved;
- let the delay-slot instruction be fetched, then issue one PC redirect pulse;
- produce the link write and delay-slot flag;
- abandon everything on an exception flush.

It also keeps two saturating performance counters.

---
 rtl/branch_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 25 ++
 rtl/branch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the decode-stage branch sequencer.
//   brState_e : sequencer state (idle / waiting on operands / awaiting delay-slot fetch)
//   LINK_REG  : architectural link register ($31)
//   DefaultAddrW, DefaultCntW : default PC and performance-counter widths
package branch_ctrl_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultCntW  = 32;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitOp = 2'd1,
    StSlot   = 2'd2
  } brState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high reset to zero
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + One;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Decode-stage branch sequencer: turns the branch judge's per-cycle verdict into
// operand stalls, a single PC redirect strobe after the delay slot is fetched, the
// link write and the delay-slot flag. Exception flush abandons any pending action.
//   Inputs : clk, rst, id_valid, branch_insn_D, BranchD, branch_taken, RegWriteBD,
//            target_D, pc_plus8_D, operand_ready_D, slot_fetched, flush_exc
//   Outputs: StallF/StallD (operand wait), redirect_valid/redirect_pc,
//            link_we/link_data, ds_flag_D, taken_cnt, stall_cnt
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              branch_insn_D,
  input  logic              BranchD,
  input  logic              branch_taken,
  input  logic              RegWriteBD,
  input  logic [ADDR_W-1:0] target_D,
  input  logic [ADDR_W-1:0] pc_plus8_D,
  input  logic              operand_ready_D,
  input  logic              slot_fetched,
  input  logic              flush_exc,
  output logic              StallF,
  output logic              StallD,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              ds_flag_D,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  brState_e          stateQ, stateD;
  logic [ADDR_W-1:0] tgtQ, tgtD;
  logic [ADDR_W-1:0] linkQ, linkD;
  logic              linkPendQ, linkPendD;
  logic              dsQ, dsD;
  logic              resolve;
  logic              opStall;

  // BranchD already folds in the taken condition; the raw verdict is not needed here.
  logic unusedTaken;
  assign unusedTaken = branch_taken;

  // A branch can only resolve while no earlier redirect is outstanding.
  assign resolve = (stateQ != StSlot) && id_valid && branch_insn_D && operand_ready_D &&
                   !flush_exc;
  assign opStall = (stateQ == StWaitOp);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      tgtQ      <= '0;
      linkQ     <= '0;
      linkPendQ <= 1'b0;
      dsQ       <= 1'b0;
    end else begin
      stateQ    <= stateD;
      tgtQ      <= tgtD;
      linkQ     <= linkD;
      linkPendQ <= linkPendD;
      dsQ       <= dsD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD    = stateQ;
    tgtD      = tgtQ;
    linkD     = linkQ;
    linkPendD = resolve && RegWriteBD;
    dsD       = dsQ;

    if (flush_exc) begin
      stateD    = StIdle;
      tgtD      = '0;
      linkD     = '0;
      linkPendD = 1'b0;
      dsD       = 1'b0;
    end else begin
      unique case (stateQ)
        StIdle, StWaitOp: begin
          if (resolve && BranchD) begin
            stateD = StSlot;
          end else if (id_valid && branch_insn_D && !operand_ready_D) begin
            stateD = StWaitOp;
          end else begin
            stateD = StIdle;
          end
        end
        StSlot: begin
          // Wait here as long as IF is stalled on the delay-slot fetch.
          if (slot_fetched) stateD = StIdle;
        end
        default: stateD = StIdle;
      endcase

      if (resolve && BranchD) tgtD = target_D;
      if (resolve && RegWriteBD) linkD = pc_plus8_D;

      // The first instruction to leave ID after a resolve is the delay slot.
      if (resolve) begin
        dsD = 1'b1;
      end else if (dsQ && id_valid && !opStall) begin
        dsD = 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    StallF         = opStall;
    StallD         = opStall;
    redirect_valid = (stateQ == StSlot) && slot_fetched && !flush_exc;
    redirect_pc    = tgtQ;
    link_we        = linkPendQ && !flush_exc;
    link_data      = linkQ;
    ds_flag_D      = dsQ;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_taken_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (resolve && BranchD),
    .count(taken_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (opStall),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, idv, br, bd, tk, rw, rdy, sf, fl;
  logic [31:0] tgt, pc8;

  logic        stallF, stallD, rv, lwe, ds;
  logic [31:0] rpc, ldat, takenCnt, stallCnt;
  logic        stallFS, stallDS, rvS, lweS, dsS;
  logic [31:0] rpcS, ldatS;
  logic [3:0]  takenCntS, stallCntS;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding work expressed as flags/values, counts as plain integers.
  bit          mWait, mSlot, mLinkPend, mDs;
  logic [31:0] mTgt, mLink;
  longint      mTaken, mStall;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(idv), .branch_insn_D(br), .BranchD(bd),
    .branch_taken(tk), .RegWriteBD(rw), .target_D(tgt), .pc_plus8_D(pc8),
    .operand_ready_D(rdy), .slot_fetched(sf), .flush_exc(fl),
    .StallF(stallF), .StallD(stallD), .redirect_valid(rv), .redirect_pc(rpc),
    .link_we(lwe), .link_data(ldat), .ds_flag_D(ds), .taken_cnt(takenCnt),
    .stall_cnt(stallCnt)
  );

  branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .id_valid(idv), .branch_insn_D(br), .BranchD(bd),
    .branch_taken(tk), .RegWriteBD(rw), .target_D(tgt), .pc_plus8_D(pc8),
    .operand_ready_D(rdy), .slot_fetched(sf), .flush_exc(fl),
    .StallF(stallFS), .StallD(stallDS), .redirect_valid(rvS), .redirect_pc(rpcS),
    .link_we(lweS), .link_data(ldatS), .ds_flag_D(dsS), .taken_cnt(takenCntS),
    .stall_cnt(stallCntS)
  );

  typedef struct {
    logic        rst, idv, br, bd, rw, rdy, sf, fl;
    logic [31:0] tgt, pc8;
    logic        eStl, eRv;
    logic [31:0] eRpc;
    logic        eLwe;
    logic [31:0] eLdat;
    logic        eDs;
    int          eTk, eSc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic i, logic b, logic d, logic w, logic y, logic s,
                              logic f, logic [31:0] t, logic [31:0] p, logic eStl, logic eRv,
                              logic [31:0] eRpc, logic eLwe, logic [31:0] eLdat, logic eDs,
                              int eTk, int eSc);
    vec_t v;
    v.rst = r; v.idv = i; v.br = b; v.bd = d; v.rw = w; v.rdy = y; v.sf = s; v.fl = f;
    v.tgt = t; v.pc8 = p; v.eStl = eStl; v.eRv = eRv; v.eRpc = eRpc; v.eLwe = eLwe;
    v.eLdat = eLdat; v.eDs = eDs; v.eTk = eTk; v.eSc = eSc;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelCheck();
    bit eRv, eLwe;
    eRv  = mSlot && sf && !fl;
    eLwe = mLinkPend && !fl;
    chk("m.StallF", stallF, mWait);
    chk("m.StallD", stallD, mWait);
    chk("m.redirect_valid", rv, eRv);
    if (eRv) chk("m.redirect_pc", rpc, mTgt);
    chk("m.link_we", lwe, eLwe);
    if (eLwe) chk("m.link_data", ldat, mLink);
    chk("m.ds_flag_D", ds, mDs);
    chk("m.rv_vs_stall", rv & stallF, 0);
    chk("m.taken_cnt", takenCnt, sat(mTaken, 64'hFFFF_FFFF));
    chk("m.stall_cnt", stallCnt, sat(mStall, 64'hFFFF_FFFF));
    chk("m.taken_cnt4", takenCntS, sat(mTaken, 15));
    chk("m.stall_cnt4", stallCntS, sat(mStall, 15));
  endtask

  task automatic modelStep();
    bit res;
    res = !mSlot && idv && br && rdy && !fl;
    if (rst) begin
      mWait = 0; mSlot = 0; mLinkPend = 0; mDs = 0;
      mTgt = '0; mLink = '0; mTaken = 0; mStall = 0;
    end else begin
      if (mWait) mStall++;
      if (res && bd) mTaken++;
      if (fl) begin
        mWait = 0; mSlot = 0; mLinkPend = 0; mDs = 0; mTgt = '0; mLink = '0;
      end else begin
        if (res) mDs = 1;
        else if (mDs && idv && !mWait) mDs = 0;
        mLinkPend = res && rw;
        if (res && rw) mLink = pc8;
        if (mSlot) begin
          if (sf) mSlot = 0;
        end else if (res) begin
          mWait = 0;
          if (bd) begin
            mSlot = 1;
            mTgt  = tgt;
          end
        end else begin
          mWait = idv && br && !rdy;
        end
      end
    end
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic finishCycle();
    modelCheck();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic cycle();
    #4;
    finishCycle();
  endtask

  task automatic idle();
    rst = 0; idv = 0; br = 0; bd = 0; tk = 0; rw = 0; rdy = 0; sf = 0; fl = 0;
    tgt = '0; pc8 = '0;
  endtask

  localparam logic [31:0] TJ = 32'hBFC0_0100;
  localparam logic [31:0] TB = 32'h8000_0200;
  localparam logic [31:0] TL = 32'h8000_1000;
  localparam logic [31:0] PL = 32'h8000_0018;
  localparam logic [31:0] TF = 32'h1234_5678;

  initial begin
    // Not-taken beq, operands ready
    vecs.push_back(mk(0,1,1,0,0,1,0,0, 0, 0,   0,0,0, 0,0, 0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,1,0,0, 0, 0,   0,0,0, 0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 0,0));
    // j with slot fetched next cycle
    vecs.push_back(mk(0,1,1,1,0,1,0,0, TJ, 0,  0,0,0, 0,0, 0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,1,1,0, 0, 0,   0,1,TJ, 0,0, 1, 1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 1,0));
    // bne, operands late for 3 cycles
    vecs.push_back(mk(0,1,1,1,0,0,0,0, TB, 0,  0,0,0, 0,0, 0, 1,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,0, TB, 0,  1,0,0, 0,0, 0, 1,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,0, TB, 0,  1,0,0, 0,0, 0, 1,1));
    vecs.push_back(mk(0,1,1,1,0,1,0,0, TB, 0,  1,0,0, 0,0, 0, 1,2));
    vecs.push_back(mk(0,1,0,0,0,1,1,0, 0, 0,   0,1,TB, 0,0, 1, 2,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 2,3));
    // jal, slot fetch delayed 4 cycles
    vecs.push_back(mk(0,1,1,1,1,1,0,0, TL, PL, 0,0,0, 0,0, 0, 2,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 1,PL, 1, 3,3));
    vecs.push_back(mk(0,1,0,0,0,1,0,0, 0, 0,   0,0,0, 0,0, 1, 3,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 3,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 3,3));
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0, 0,   0,1,TL, 0,0, 0, 3,3));
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0, 0,   0,0,0, 0,0, 0, 3,3));
    // flush together with slot_fetched in SLOT
    vecs.push_back(mk(0,1,1,1,0,1,0,0, TF, 0,  0,0,0, 0,0, 0, 3,3));
    vecs.push_back(mk(0,0,0,0,0,0,1,1, 0, 0,   0,0,0, 0,0, 1, 4,3));
    vecs.push_back(mk(0,0,0,0,0,0,1,0, 0, 0,   0,0,0, 0,0, 0, 4,3));
    // rst during WAIT_OP
    vecs.push_back(mk(0,1,1,1,0,0,0,0, TB, 0,  0,0,0, 0,0, 0, 4,3));
    vecs.push_back(mk(0,1,1,1,0,0,0,0, TB, 0,  1,0,0, 0,0, 0, 4,3));
    vecs.push_back(mk(1,1,1,1,0,0,0,0, TB, 0,  1,0,0, 0,0, 0, 4,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0, 0,   0,0,0, 0,0, 0, 0,0));

    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;

    // Reset state
    #4;
    chk("rst.StallF", stallF, 0);
    chk("rst.StallD", stallD, 0);
    chk("rst.redirect_valid", rv, 0);
    chk("rst.redirect_pc", rpc, 0);
    chk("rst.link_we", lwe, 0);
    chk("rst.link_data", ldat, 0);
    chk("rst.ds_flag_D", ds, 0);
    chk("rst.taken_cnt", takenCnt, 0);
    chk("rst.stall_cnt", stallCnt, 0);
    finishCycle();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; idv = vecs[i].idv; br = vecs[i].br; bd = vecs[i].bd;
      tk = vecs[i].bd; rw = vecs[i].rw; rdy = vecs[i].rdy; sf = vecs[i].sf;
      fl = vecs[i].fl; tgt = vecs[i].tgt; pc8 = vecs[i].pc8;
      #4;
      chk($sformatf("v%0d.stall", i), stallF, vecs[i].eStl);
      chk($sformatf("v%0d.redirect_valid", i), rv, vecs[i].eRv);
      if (vecs[i].eRv) chk($sformatf("v%0d.redirect_pc", i), rpc, vecs[i].eRpc);
      chk($sformatf("v%0d.link_we", i), lwe, vecs[i].eLwe);
      if (vecs[i].eLwe) chk($sformatf("v%0d.link_data", i), ldat, vecs[i].eLdat);
      chk($sformatf("v%0d.ds_flag_D", i), ds, vecs[i].eDs);
      chk($sformatf("v%0d.taken_cnt", i), takenCnt, 64'(vecs[i].eTk));
      chk($sformatf("v%0d.stall_cnt", i), stallCnt, 64'(vecs[i].eSc));
      finishCycle();
    end

    // Saturation: 20 taken branches on the 4-bit instance
    idle();
    rst = 1;
    cycle();
    rst = 0;
    for (int n = 0; n < 20; n++) begin
      idv = 1; br = 1; bd = 1; tk = 1; rdy = 1; sf = 0; tgt = 32'h100 + n;
      cycle();
      idv = 1; br = 0; bd = 0; tk = 0; sf = 1;
      cycle();
    end
    idle();
    #4;
    chk("sat.taken_cnt4", takenCntS, 15);
    chk("sat.taken_cnt32", takenCnt, 20);
    finishCycle();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      idv = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 2) == 0);
      bd  = $urandom_range(0, 1) != 0;
      tk  = bd;
      rw  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sf  = $urandom_range(0, 1) != 0;
      tgt = $urandom;
      pc8 = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
